data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, address width; it matches the external address bus.
REQ-002 Parameter DATA_W, default 16, data width; it matches the external data bus.
REQ-003 Parameter RAM_WAIT, default 1, wait cycles per RAM access; legal range 0..7.
REQ-004 Parameter ROM_WAIT, default 2, wait cycles per ROM access; legal range 1..7.
REQ-005 Port i_clk, input, 1, clock; all state changes on its rising edge.
REQ-006 Port i_rst_n, input, 1, reset: synchronous, active-low.
REQ-007 Port i_rom_read, input, 1, level strobe from the external bus: instruction fetch.
REQ-008 Port i_ram_read, input, 1, level strobe from the external bus: data read.
REQ-009 Port i_ram_write, input, 1, level strobe from the external bus: data write.
REQ-010 Port i_addr, input, ADDR_W, memory address from the external bus.
REQ-011 Port i_wdata, input, DATA_W, write data from the external bus.
REQ-012 Port o_instr, output, DATA_W, last fetched instruction; feeds the bus instruction input.
REQ-013 Port o_data, output, DATA_W, last RAM read data; feeds the bus data input.
REQ-014 Port o_ready, output, 1, one-cycle pulse marking access completion.
REQ-015 Port o_busy, output, 1, high in every state except IDLE.
REQ-016 Port o_err, output, 1, one-cycle pulse when more than one strobe is high in IDLE.
REQ-017 Port o_rom_addr, output, ADDR_W, address to the external synchronous ROM.
REQ-018 Port o_rom_en, output, 1, ROM read enable.
REQ-019 Port i_rom_data, input, DATA_W, ROM read data, valid the cycle after o_rom_en.

Function
REQ-020 Controller SHALL be an FSM with states IDLE, WAIT, DONE and HOLD.
REQ-021 In IDLE with exactly one strobe high: latch i_addr, i_wdata and op; load the wait counter with RAM_WAIT or ROM_WAIT; go to WAIT, or to DONE if the loaded count is 0.
REQ-022 In IDLE with two or more strobes high: pulse o_err, latch nothing, go to HOLD.
REQ-023 In WAIT: decrement the counter each cycle; go to DONE when the counter equals 1.
REQ-024 RAM write SHALL commit to internal storage on the cycle that enters DONE.
REQ-025 RAM read SHALL update o_data on the cycle that enters DONE.
REQ-026 ROM fetch: o_rom_addr SHALL equal the latched address and o_rom_en SHALL be high throughout WAIT.
REQ-027 ROM fetch: o_instr SHALL capture i_rom_data on the cycle that enters DONE.
REQ-028 Access latency SHALL be 1+WAIT cycles from strobe sample to o_ready high.
REQ-029 DONE SHALL last exactly one cycle, with o_ready high.
REQ-030 DONE SHALL go to HOLD if any strobe is still high, otherwise to IDLE.
REQ-031 HOLD SHALL go to IDLE when all strobes are low; this allows one access per strobe assertion.
REQ-032 Strobe changes and i_addr/i_wdata changes outside IDLE SHALL be ignored, because latched values are used.
REQ-033 o_data and o_instr SHALL hold their value until the next completing access of their type.
REQ-034 Address arithmetic SHALL be the full ADDR_W index, covering 0..2^ADDR_W-1, with no wrap logic.

Reset
REQ-035 On i_rst_n low at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-036 On reset, o_ready, o_err, o_rom_en, o_data, o_instr and o_rom_addr SHALL go to 0.
REQ-037 A reset during WAIT SHALL abort the access, and a pending write SHALL NOT commit.
REQ-038 RAM contents SHALL NOT be altered by reset.

Structure
REQ-039 The shared package cpu_mem_pkg SHALL hold the FSM state enum, the op enum (OP_ROM, OP_RD, OP_WR) and the ADDR_W/DATA_W defaults.
REQ-040 The design SHALL use one sub-module, ram_sp_256x16: a single-port synchronous RAM with we, addr, wdata and registered rdata.
REQ-041 All control logic SHALL live in data_mem_ctrl, with no further hierarchy.

Verification
REQ-042 Write then read: write 0xA5A5 to 0x10 (RAM_WAIT=1), then read 0x10 -> o_ready 2 cycles after each strobe; o_data=0xA5A5.
REQ-043 ROM fetch: i_rom_read at addr 0x03 with i_rom_data=0x1234 (ROM_WAIT=2) -> o_rom_en high 2 cycles; o_instr=0x1234; o_ready at cycle 3.
REQ-044 Held strobe: i_ram_read held 10 cycles -> exactly one o_ready pulse; FSM stays in HOLD until the strobe drops.
REQ-045 Conflict: i_ram_read and i_ram_write both high in IDLE -> o_err one cycle; no o_ready; RAM unchanged.
REQ-046 Abort: reset asserted in WAIT of a write of 0xFFFF to 0x20 -> later read of 0x20 returns its prior value; all outputs 0 after reset.
REQ-047 Zero wait: RAM_WAIT=0 with a read of 0xFF -> o_ready on the cycle after the strobe sample; boundary address accessed correctly.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the data/instruction memory controller.
package cpu_mem_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_HOLD} state_e;
    typedef enum logic [1:0] {OP_ROM, OP_RD, OP_WR} op_e;

    function automatic logic [1:0] strobe_cnt(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction
endpackage

// File: rtl/ram_sp_256x16.sv
// Single-port synchronous RAM, read-first, registered read data, no reset on storage.
module ram_sp_256x16 #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_ctrl.sv
// Bus-to-memory controller: one access per strobe assertion, RAM on-chip, ROM external.
module data_mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RAM_WAIT = 1,
    parameter int ROM_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rom_read,
    input  logic              i_ram_read,
    input  logic              i_ram_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_instr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_en,
    input  logic [DATA_W-1:0] i_rom_data
);
    localparam logic [CNT_W-1:0] LD_RAM = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] LD_ROM = CNT_W'(ROM_WAIT);

    state_e              r_state;
    op_e                 r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_data;

    logic                w_any;
    logic [1:0]          w_nstb;
    op_e                 w_op;
    logic [CNT_W-1:0]    w_load;
    logic                w_accept;
    logic                w_last;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_rdata;

    assign w_any    = i_rom_read | i_ram_read | i_ram_write;
    assign w_nstb   = strobe_cnt(i_rom_read, i_ram_read, i_ram_write);
    assign w_op     = i_rom_read ? OP_ROM : (i_ram_read ? OP_RD : OP_WR);
    assign w_load   = (w_op == OP_ROM) ? LD_ROM : LD_RAM;
    assign w_accept = (r_state == ST_IDLE) && (w_nstb == 2'd1);
    assign w_last   = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

    // Writes commit on the edge entering DONE; a zero-wait write goes straight from IDLE.
    // Gating with reset keeps an aborted write out of the array.
    assign w_ram_we    = i_rst_n && ((w_accept && w_load == '0 && w_op == OP_WR) ||
                                     (w_last && r_op == OP_WR));
    assign w_ram_addr  = (r_state == ST_IDLE) ? i_addr  : r_addr;
    assign w_ram_wdata = (r_state == ST_IDLE) ? i_wdata : r_wdata;

    ram_sp_256x16 #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    // The RAM output register already holds the read word during DONE; r_data keeps it afterwards.
    assign o_data = (r_state == ST_DONE && r_op == OP_RD) ? w_rdata : r_data;
    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ROM;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            o_instr    <= '0;
            o_ready    <= 1'b0;
            o_err      <= 1'b0;
            o_rom_en   <= 1'b0;
            o_rom_addr <= '0;
        end else begin
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_nstb > 2'd1) begin
                        o_err   <= 1'b1;
                        r_state <= ST_HOLD;
                    end else if (w_nstb == 2'd1) begin
                        r_op    <= w_op;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_cnt   <= w_load;
                        if (w_op == OP_ROM)
                            o_rom_addr <= i_addr;
                        if (w_load == '0) begin
                            r_state <= ST_DONE;
                            o_ready <= 1'b1;
                        end else begin
                            r_state  <= ST_WAIT;
                            o_rom_en <= (w_op == OP_ROM);
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= ST_DONE;
                        o_ready  <= 1'b1;
                        o_rom_en <= 1'b0;
                        if (r_op == OP_ROM)
                            o_instr <= i_rom_data;
                    end
                end
                ST_DONE: begin
                    if (r_op == OP_RD)
                        r_data <= w_rdata;
                    r_state <= w_any ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!w_any)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus randomized bench for data_mem_ctrl; two instances cover RAM_WAIT=1 and RAM_WAIT=0.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_rd, ram_rd, ram_wr, rom_rd_z, ram_rd_z, ram_wr_z;
    logic [7:0]  addr, addr_z, rom_addr, rom_addr_z;
    logic [15:0] wdata, wdata_z, instr, instr_z, data, data_z, rom_data, rom_data_z;
    logic        ready, busy, err, rom_en, ready_z, busy_z, err_z, rom_en_z;

    int vecs = 0;
    int errs = 0;
    logic [15:0] rom   [256];
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];

    always #5 clk = ~clk;

    data_mem_ctrl #(.RAM_WAIT(1), .ROM_WAIT(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rom_read(rom_rd), .i_ram_read(ram_rd),
        .i_ram_write(ram_wr), .i_addr(addr), .i_wdata(wdata), .o_instr(instr),
        .o_data(data), .o_ready(ready), .o_busy(busy), .o_err(err),
        .o_rom_addr(rom_addr), .o_rom_en(rom_en), .i_rom_data(rom_data));

    data_mem_ctrl #(.RAM_WAIT(0), .ROM_WAIT(2)) u_dut_z (
        .i_clk(clk), .i_rst_n(rst_n), .i_rom_read(rom_rd_z), .i_ram_read(ram_rd_z),
        .i_ram_write(ram_wr_z), .i_addr(addr_z), .i_wdata(wdata_z), .o_instr(instr_z),
        .o_data(data_z), .o_ready(ready_z), .o_busy(busy_z), .o_err(err_z),
        .o_rom_addr(rom_addr_z), .o_rom_en(rom_en_z), .i_rom_data(rom_data_z));

    // Behavioural synchronous ROM: data valid the cycle after enable.
    always @(posedge clk) begin
        if (rom_en)   rom_data   <= rom[rom_addr];
        if (rom_en_z) rom_data_z <= rom[rom_addr_z];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // op: 0 = rom fetch, 1 = ram read, 2 = ram write, anything else = all strobes low
    task automatic drive(input bit z, input int op, input logic [7:0] a, input logic [15:0] d);
        if (z) begin
            rom_rd_z = (op == 0); ram_rd_z = (op == 1); ram_wr_z = (op == 2);
            addr_z = a; wdata_z = d;
        end else begin
            rom_rd = (op == 0); ram_rd = (op == 1); ram_wr = (op == 2);
            addr = a; wdata = d;
        end
    endtask

    // One full access; returns latency in cycles (99 on timeout), ROM-enable cycles,
    // and the data/instruction seen while o_ready is high. Returns with the FSM back in IDLE.
    task automatic access(input bit z, input int op, input logic [7:0] a, input logic [15:0] d,
                          output int lat, output int en_cnt, output logic [15:0] od, output logic [15:0] oi);
        @(negedge clk);
        drive(z, op, a, d);
        lat = 99; en_cnt = 0; od = 'x; oi = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((z ? rom_en_z : rom_en) && (z ? rom_addr_z : rom_addr) == a) en_cnt++;
            if (z ? ready_z : ready) begin
                lat = i;
                od = z ? data_z : data;
                oi = z ? instr_z : instr;
                break;
            end
        end
        drive(z, 3, a, d);
        @(posedge clk); #1;
        chk("ready_pulse_end", {31'b0, z ? ready_z : ready}, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a"}, {ready, err, rom_en, busy, data, instr, rom_addr}, 0);
        chk({tag, "_z"}, {ready_z, err_z, rom_en_z, busy_z, data_z, instr_z, rom_addr_z}, 0);
    endtask

    initial begin
        int lat, en_cnt, pulses, op;
        logic [15:0] od, oi, d, last_rd_a, last_rd_b, last_in_a, last_in_b;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[3] = 16'h1234;
        rst_n = 1'b0;
        drive(0, 3, 8'h00, 16'h0000);
        drive(1, 3, 8'h00, 16'h0000);
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset_init");
        @(negedge clk) rst_n = 1'b1;

        // Write then read at 0x10, two-cycle latency each
        access(0, 2, 8'h10, 16'hA5A5, lat, en_cnt, od, oi);
        mem_a[8'h10] = 16'hA5A5; q_a.push_back(8'h10);
        chk("wr_lat", lat, 2);
        access(0, 1, 8'h10, 16'h0000, lat, en_cnt, od, oi);
        chk("rd_lat", lat, 2);
        chk("rd_data", od, 16'hA5A5);
        chk("rd_hold", data, 16'hA5A5);

        // ROM fetch at 0x03
        access(0, 0, 8'h03, 16'h0000, lat, en_cnt, od, oi);
        chk("rom_lat", lat, 3);
        chk("rom_en_cycles", en_cnt, 2);
        chk("rom_instr", oi, 16'h1234);
        chk("rom_data_keep", data, 16'hA5A5);

        // Held read strobe: one pulse, HOLD until release
        @(negedge clk) drive(0, 1, 8'h10, 16'h0000);
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        chk("held_pulses", pulses, 1);
        chk("held_busy", {31'b0, busy}, 1);
        drive(0, 3, 8'h00, 16'h0000);
        @(posedge clk); #1;
        chk("held_release", {31'b0, busy}, 0);

        // Conflicting strobes: error pulse, nothing latched
        @(negedge clk);
        ram_rd = 1'b1; ram_wr = 1'b1; addr = 8'h10; wdata = 16'h0BAD;
        @(posedge clk); #1;
        chk("conf_err", {ready, err, busy}, 3'b011);
        @(posedge clk); #1;
        chk("conf_hold", {ready, err, busy}, 3'b001);
        drive(0, 3, 8'h00, 16'h0000);
        @(posedge clk); #1;
        chk("conf_idle", {31'b0, busy}, 0);
        access(0, 1, 8'h10, 16'h0000, lat, en_cnt, od, oi);
        chk("conf_ram_intact", od, 16'hA5A5);

        // Reset during the wait of a write aborts it
        access(0, 2, 8'h20, 16'h1357, lat, en_cnt, od, oi);
        mem_a[8'h20] = 16'h1357; q_a.push_back(8'h20);
        @(negedge clk) drive(0, 2, 8'h20, 16'hFFFF);
        @(posedge clk); #1;
        chk("abort_in_wait", {31'b0, busy}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 3, 8'h00, 16'h0000);
        @(posedge clk); #1;
        chk_reset_outputs("abort_reset");
        @(negedge clk) rst_n = 1'b1;
        access(0, 1, 8'h20, 16'h0000, lat, en_cnt, od, oi);
        chk("abort_prior", od, 16'h1357);
        last_rd_a = 16'h1357; last_in_a = 16'h0000;

        // Zero-wait RAM on the second instance, both address extremes
        access(1, 2, 8'hFF, 16'hBEEF, lat, en_cnt, od, oi);
        mem_b[8'hFF] = 16'hBEEF; q_b.push_back(8'hFF);
        chk("z_wr_lat", lat, 1);
        access(1, 2, 8'h00, 16'h1111, lat, en_cnt, od, oi);
        mem_b[8'h00] = 16'h1111; q_b.push_back(8'h00);
        access(1, 1, 8'hFF, 16'h0000, lat, en_cnt, od, oi);
        chk("z_rd_lat", lat, 1);
        chk("z_rd_ff", od, 16'hBEEF);
        access(1, 1, 8'h00, 16'h0000, lat, en_cnt, od, oi);
        chk("z_rd_00", od, 16'h1111);
        last_rd_b = 16'h1111; last_in_b = 16'h0000;

        // Randomized traffic on both instances against the array model
        for (int n = 0; n < 60; n++) begin
            bit z;
            z  = (n % 3 == 2);
            op = $urandom_range(0, 2);
            a  = 8'($urandom);
            d  = 16'($urandom);
            if (op == 1) a = z ? q_b[$urandom_range(0, q_b.size() - 1)] : q_a[$urandom_range(0, q_a.size() - 1)];
            access(z, op, a, d, lat, en_cnt, od, oi);
            chk("rnd_lat", lat, (op == 0) ? 3 : (z ? 1 : 2));
            case (op)
                0: begin
                    chk("rnd_instr", oi, rom[a]);
                    if (z) last_in_b = rom[a]; else last_in_a = rom[a];
                end
                1: begin
                    chk("rnd_rdata", od, z ? mem_b[a] : mem_a[a]);
                    if (z) last_rd_b = od; else last_rd_a = od;
                end
                default: begin
                    if (z) begin mem_b[a] = d; q_b.push_back(a); end
                    else begin mem_a[a] = d; q_a.push_back(a); end
                end
            endcase
            chk("rnd_data_hold", z ? data_z : data, z ? last_rd_b : last_rd_a);
            chk("rnd_instr_hold", z ? instr_z : instr, z ? last_in_b : last_in_a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
